sd_fifo_headrd: RTL

- Shift-register FIFO, the read-side counterpart of the tail-write FIFO.
- The consumer always reads entry 0, so p_data is a flop output with no read mux.
- Writes land at a variable pointer derived from usage; every pop shifts the whole buffer one place toward the head.
- Used where output timing is critical and depth is small: link egress stages and pipeline-boundary skid storage in the srdy/drdy fabric.

---
 rtl/sd_fifo_headrd.sv | 89 ++++++++
 1 files changed

// File: rtl/sd_fifo_headrd.sv
// sd_fifo_headrd: shift-register FIFO whose head is always entry 0, so p_data comes straight from flops.
// Optional macro SD_FIFO_HEADRD_ZERO_EN: storage resets to 0 and the vacated top entry is zeroed on each pop.
module sd_fifo_headrd #(
    parameter int width = 8,
    parameter int depth = 4,
    parameter int usz   = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] c_data,
    input  logic             c_srdy,
    output logic             c_drdy,
    output logic [width-1:0] p_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [usz-1:0]   nxt_usage,
    output logic [usz-1:0]   usage
);

    logic [usz-1:0]   r_usage;
    logic [width-1:0] r_buf      [depth];
    logic [width-1:0] w_buf_next [depth];
    logic             w_wr;
    logic             w_rd;
    logic [usz-1:0]   w_wi;
    logic [usz-1:0]   w_nxt_usage;

    // Full blocks writes even when a pop happens in the same cycle, keeping c_drdy off the p_drdy path.
    assign c_drdy      = (r_usage < usz'(depth));
    assign p_srdy      = (r_usage != '0);
    assign w_wr        = c_srdy & c_drdy;
    assign w_rd        = p_srdy & p_drdy;
    assign w_nxt_usage = r_usage + usz'(w_wr) - usz'(w_rd);
    assign w_wi        = r_usage - usz'(w_rd);
    assign nxt_usage   = reset ? '0 : w_nxt_usage;
    assign usage       = r_usage;
    assign p_data      = r_buf[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_usage <= '0;
        end else begin
            r_usage <= w_nxt_usage;
        end
    end

    // Pop shifts everything toward the head; a write on the same index takes priority.
    always_comb begin
        for (int i = 0; i < depth; i++) begin
            w_buf_next[i] = r_buf[i];
        end
        if (w_rd) begin
            for (int i = 0; i < depth - 1; i++) begin
                w_buf_next[i] = r_buf[i + 1];
            end
`ifdef SD_FIFO_HEADRD_ZERO_EN
            w_buf_next[depth-1] = '0;
`endif
        end
        if (w_wr) begin
            for (int i = 0; i < depth; i++) begin
                if (w_wi == usz'(i)) begin
                    w_buf_next[i] = c_data;
                end
            end
        end
    end

`ifdef SD_FIFO_HEADRD_ZERO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < depth; i++) begin
            r_buf[i] <= w_buf_next[i];
        end
    end
`endif

endmodule
